// File: rtl/arith_seq_pkg.sv
// Shared types for the resource-shared six-result arithmetic evaluator:
// FSM state encoding, multiplier operand selection and the default width.
package arith_seq_pkg;

   localparam int WIDTH_DEF = 32;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      SUM,
      MUL4,
      MUL6,
      OUT
   } state_e;

   typedef enum logic [1:0] {
      SEL_CD,
      SEL_US,
      SEL_VQ
   } mul_sel_e;

endpackage

// File: rtl/arith_seq_evaluator_if.sv
// Operand/result bundle bus: valid/ready in, valid/ready out.
// A transfer happens on a rising edge where valid and ready are both high;
// the sender holds valid and its payload stable until that edge.
interface arith_seq_evaluator_if
   import arith_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result1, result2, result3, result4, result5, result6;

   modport master (
      output in_valid, a, b, c, d, e, f, g, h, out_ready,
      input  in_ready, out_valid,
             result1, result2, result3, result4, result5, result6
   );

   modport slave (
      input  in_valid, a, b, c, d, e, f, g, h, out_ready,
      output in_ready, out_valid,
             result1, result2, result3, result4, result5, result6
   );
endinterface

// File: rtl/arith_seq_evaluator_shared_mul.sv
// The evaluator's single combinational multiplier; the select picks which
// operand pair it serves in the current schedule step. Low WIDTH bits only.
module shared_mul
   import arith_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  mul_sel_e         sel,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] u,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] v,
   input  logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] prod
);
   logic [WIDTH-1:0] op_x;
   logic [WIDTH-1:0] op_y;

   always_comb begin
      op_x = c;
      op_y = d;
      case (sel)
         SEL_US: begin
            op_x = u;
            op_y = s;
         end
         SEL_VQ: begin
            op_x = v;
            op_y = q;
         end
         default: begin
            op_x = c;
            op_y = d;
         end
      endcase
      prod = op_x * op_y;
   end
endmodule

// File: rtl/arith_seq_evaluator.sv
// Sequential six-result evaluator: latch a..h, then a fixed PRE/SUM/MUL4/MUL6
// schedule around one shared multiplier, then hold the bundle in OUT.
module arith_seq_evaluator
   import arith_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   arith_seq_evaluator_if.slave bus,
   output logic [CNT_W-1:0]  done_count,
   output state_e            state_dbg
);
   state_e           state, state_n;
   mul_sel_e         mul_sel;
   logic             in_ready_w, out_valid_w;
   logic [WIDTH-1:0] ra, rb, rc, rd, re, rf, rg, rh;
   logic [WIDTH-1:0] s, p, q, t, u, v;
   logic [WIDTH-1:0] r1, r2, r3, r4, r5, r6;
   logic [WIDTH-1:0] prod;

   shared_mul #(.WIDTH(WIDTH)) u_mul (
      .sel  (mul_sel),
      .c    (rc),
      .d    (rd),
      .u    (u),
      .s    (s),
      .v    (v),
      .q    (q),
      .prod (prod)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (bus.in_valid) state_n = PRE;
         PRE:     state_n = SUM;
         SUM:     state_n = MUL4;
         MUL4:    state_n = MUL6;
         MUL6:    state_n = OUT;
         OUT:     if (bus.out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      in_ready_w  = (state == IDLE);
      out_valid_w = (state == OUT);
      mul_sel     = SEL_CD;
      case (state)
         MUL4:    mul_sel = SEL_US;
         MUL6:    mul_sel = SEL_VQ;
         default: mul_sel = SEL_CD;
      endcase
   end

   // Each state writes only its own registers; everything else holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {ra, rb, rc, rd, re, rf, rg, rh} <= '0;
         {s, p, q, t, u, v}               <= '0;
         {r1, r2, r3, r4, r5, r6}         <= '0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               ra <= bus.a; rb <= bus.b; rc <= bus.c; rd <= bus.d;
               re <= bus.e; rf <= bus.f; rg <= bus.g; rh <= bus.h;
            end
            PRE: begin
               s <= ra + rb;
               p <= prod;
               q <= re - rf;
               t <= rg + rh;
            end
            SUM: begin
               r1 <= s + p;
               r2 <= p + q;
               r3 <= s + t;
               r5 <= (p + rb) - (rf + s);
               u  <= p + re;
               v  <= s + rc;
            end
            MUL4:    r4 <= prod;
            MUL6:    r6 <= prod;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                done_count <= '0;
      else if (state == OUT && bus.out_ready)    done_count <= done_count + 1'b1;
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = out_valid_w;
   assign bus.result1   = r1;
   assign bus.result2   = r2;
   assign bus.result3   = r3;
   assign bus.result4   = r4;
   assign bus.result5   = r5;
   assign bus.result6   = r6;
   assign state_dbg     = state;
endmodule
